// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : Sequencing stage between the memory address decoder and the
//                data memory / VGA / I/O devices of the MIPS32 SoC. Accepts a
//                CPU read or write request together with the decoded address,
//                the one-hot target enable and the read-data select. It then
//                drives exactly one device enable, stalls the CPU until the
//                access completes, and registers the returned read data.
//                Decode errors and VGA timeouts are reported as a one-cycle
//                addr_err pulse.
//
//  Optional    : MEM_BUS_STATS_EN - when defined, acc_cnt and err_cnt are
//                saturating 16-bit counters of completed accesses and error
//                pulses. When undefined, both outputs are tied to zero.
//
//  Ports       : clk, rst_n             clock, async active-low reset
//                mR, mW                 CPU read / write request
//                pAd                    decoded physical address
//                mE                     target one-hot {io, vga, dm}
//                mB                     read select 00 dm, 01 vga, 10 io
//                iAd                    invalid-address flag from decoder
//                wdata                  CPU write data
//                dm/vga/io_rdata        device read data
//                vga_ready              VGA access-complete strobe
//                dev_addr, dev_wdata    registered address / write data
//                dm_en, vga_en, io_en   device enables
//                dev_we                 write strobe (only with an enable)
//                rdata                  registered read data to the CPU
//                stall                  CPU hold
//                addr_err               one-cycle error pulse
//                acc_cnt, err_cnt       statistics counters (optional)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int VGA_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mR,
    input  logic              mW,
    input  logic [ADDR_W-1:0] pAd,
    input  logic [2:0]        mE,
    input  logic [1:0]        mB,
    input  logic              iAd,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic [DATA_W-1:0] vga_rdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              vga_ready,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    output logic              dm_en,
    output logic              vga_en,
    output logic              io_en,
    output logic              dev_we,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              addr_err,
    output logic [15:0]       acc_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int CNT_W = (VGA_TIMEOUT > 1) ? $clog2(VGA_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(VGA_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_tcnt;
    logic [1:0]        r_mb;
    logic              r_write;
    logic [ADDR_W-1:0] r_dev_addr;
    logic [DATA_W-1:0] r_dev_wdata;
    logic              r_dm_en;
    logic              r_vga_en;
    logic              r_io_en;
    logic              r_dev_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_addr_err;

    logic              w_req;
    logic              w_onehot;
    logic              w_valid;
    logic [DATA_W-1:0] w_sel_rdata;

    assign w_req    = mR | mW;
    // A zero or multi-hot enable cannot address a single device, so it is
    // handled exactly like a decoder-flagged invalid address.
    assign w_onehot = (mE == 3'b001) || (mE == 3'b010) || (mE == 3'b100);
    assign w_valid  = !iAd && w_onehot;

    always_comb begin
        w_sel_rdata = '0;
        case (r_mb)
            2'b00:   w_sel_rdata = dm_rdata;
            2'b01:   w_sel_rdata = vga_rdata;
            2'b10:   w_sel_rdata = io_rdata;
            default: w_sel_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_mb        <= 2'b00;
            r_write     <= 1'b0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_dm_en     <= 1'b0;
            r_vga_en    <= 1'b0;
            r_io_en     <= 1'b0;
            r_dev_we    <= 1'b0;
            r_rdata     <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            // Error flag is a pulse: only the transition into DONE sets it.
            r_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_valid) begin
                            r_dev_addr  <= pAd;
                            r_dev_wdata <= wdata;
                            r_mb        <= mB;
                            r_write     <= mW;   // write wins over read
                            r_dm_en     <= mE[0];
                            r_vga_en    <= mE[1];
                            r_io_en     <= mE[2];
                            r_dev_we    <= mW;
                            r_state     <= S_ACCESS;
                        end else begin
                            r_rdata    <= '0;
                            r_addr_err <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_vga_en && !vga_ready) begin
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        if (!r_write) begin
                            r_rdata <= w_sel_rdata;
                        end
                        r_dm_en  <= 1'b0;
                        r_vga_en <= 1'b0;
                        r_io_en  <= 1'b0;
                        r_dev_we <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end

                S_WAIT: begin
                    // A ready strobe on the last allowed cycle still counts
                    // as success, so it is tested before the timeout.
                    if (vga_ready) begin
                        if (!r_write) begin
                            r_rdata <= w_sel_rdata;
                        end
                        r_vga_en <= 1'b0;
                        r_dev_we <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_tcnt == c_TMO_LAST) begin
                        r_rdata    <= '0;
                        r_addr_err <= 1'b1;
                        r_vga_en   <= 1'b0;
                        r_dev_we   <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The IDLE term is combinational so the CPU is held in the same cycle it
    // raises a request; the access itself starts on the following edge.
    assign stall = (r_state == S_ACCESS) || (r_state == S_WAIT) ||
                   ((r_state == S_IDLE) && w_req);

    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_dev_wdata;
    assign dm_en     = r_dm_en;
    assign vga_en    = r_vga_en;
    assign io_en     = r_io_en;
    assign dev_we    = r_dev_we;
    assign rdata     = r_rdata;
    assign addr_err  = r_addr_err;

`ifdef MEM_BUS_STATS_EN
    logic [15:0] r_acc_cnt;
    logic [15:0] r_err_cnt;

    // Each access spends exactly one cycle in DONE; the error flag is high
    // in that cycle precisely when the access failed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= 16'h0000;
            r_err_cnt <= 16'h0000;
        end else if (r_state == S_DONE) begin
            if (r_addr_err) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end else begin
                if (r_acc_cnt != 16'hFFFF) begin
                    r_acc_cnt <= r_acc_cnt + 16'd1;
                end
            end
        end
    end

    assign acc_cnt = r_acc_cnt;
    assign err_cnt = r_err_cnt;
`else
    assign acc_cnt = 16'h0000;
    assign err_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_bus_ctrl
//  Description : Self-checking bench for mem_bus_ctrl. Expected read data and
//                error flags are pushed to a queue when a request is driven
//                and popped when the DONE cycle is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mR = 1'b0;
    logic          mW = 1'b0;
    logic [AW-1:0] pAd = '0;
    logic [2:0]    mE = 3'b000;
    logic [1:0]    mB = 2'b00;
    logic          iAd = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] dm_rdata = '0;
    logic [DW-1:0] vga_rdata = '0;
    logic [DW-1:0] io_rdata = '0;
    logic          vga_ready = 1'b0;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata;
    logic          dm_en;
    logic          vga_en;
    logic          io_en;
    logic          dev_we;
    logic [DW-1:0] rdata;
    logic          stall;
    logic          addr_err;
    logic [15:0]   acc_cnt;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .VGA_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .mR(mR), .mW(mW), .pAd(pAd), .mE(mE),
        .mB(mB), .iAd(iAd), .wdata(wdata), .dm_rdata(dm_rdata),
        .vga_rdata(vga_rdata), .io_rdata(io_rdata), .vga_ready(vga_ready),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dm_en(dm_en),
        .vga_en(vga_en), .io_en(io_en), .dev_we(dev_we), .rdata(rdata),
        .stall(stall), .addr_err(addr_err), .acc_cnt(acc_cnt),
        .err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    // Reference state
    logic [DW-1:0] m_rdata = '0;
    int            m_acc = 0;
    int            m_err = 0;

    // Observations of the most recent access
    int            obs_stall;
    int            obs_en;
    logic [2:0]    obs_en_seen;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;

    // Runs one access starting between edges. ready_at is the cycle index
    // (0 = request cycle) in which vga_ready pulses; negative means never.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [2:0] me,
                              input logic [1:0] mb, input logic iad,
                              input logic [DW-1:0] wd, input int ready_at,
                              input bit drop_early, input string name);
        exp_t e;
        exp_t got;
        bit   valid;
        int   cyc;
        int   exp_acc;
        int   exp_err;
        valid = !iad && (me == 3'b001 || me == 3'b010 || me == 3'b100);
        e.err = 1'b0;
        if (!valid || (me == 3'b010 && ready_at < 0)) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else if (wr) begin
            e.rdata = m_rdata;
        end else begin
            case (mb)
                2'b00:   e.rdata = dm_rdata;
                2'b01:   e.rdata = vga_rdata;
                2'b10:   e.rdata = io_rdata;
                default: e.rdata = '0;
            endcase
        end
        m_rdata = e.rdata;
        if (e.err) m_err++; else m_acc++;
        sb.push_back(e);

        mR = rd; mW = wr; pAd = addr; mE = me; mB = mb; iAd = iad; wdata = wd;
        obs_stall = 0; obs_en = 0; obs_en_seen = 3'b000; obs_we = 1'b0;
        obs_addr = '0; obs_wdata = '0;
        cyc = 0;
        while (cyc < 200) begin
            vga_ready = (cyc == ready_at);
            #1;
            if (stall !== 1'b1) break;
            obs_stall++;
            if (dm_en || vga_en || io_en) obs_en++;
            obs_en_seen = obs_en_seen | {io_en, vga_en, dm_en};
            obs_we = obs_we | dev_we;
            if (cyc == 1) begin
                obs_addr  = dev_addr;
                obs_wdata = dev_wdata;
                if (drop_early) begin
                    mR = 1'b0;
                    mW = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s done_timeout: stall still %b after %0d cycles, required 0", name, stall, cyc);
        end
        vga_ready = 1'b0; mR = 1'b0; mW = 1'b0; iAd = 1'b0;

        // DONE cycle
        got = sb.pop_front();
        checks++;
        if (rdata !== got.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, rdata, got.rdata);
        end
        checks++;
        if (addr_err !== got.err) begin
            errors++;
            $display("FAIL %s addr_err_done: got %b required %b", name, addr_err, got.err);
        end
        checks++;
        if ({io_en, vga_en, dm_en, dev_we} !== 4'b0000) begin
            errors++;
            $display("FAIL %s enables_done: got %b required 0000", name, {io_en, vga_en, dm_en, dev_we});
        end

        // Following IDLE cycle
        @(negedge clk);
        #1;
        checks++;
        if (addr_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: addr_err=%b stall=%b required 0 0", name, addr_err, stall);
        end
`ifdef MEM_BUS_STATS_EN
        exp_acc = m_acc;
        exp_err = m_err;
`else
        exp_acc = 0;
        exp_err = 0;
`endif
        checks++;
        if (acc_cnt !== exp_acc[15:0] || err_cnt !== exp_err[15:0]) begin
            errors++;
            $display("FAIL %s stats: acc=%0d err=%0d required %0d %0d", name, acc_cnt, err_cnt, exp_acc, exp_err);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({dm_en, vga_en, io_en, dev_we, stall, addr_err} !== 6'b0 ||
            rdata !== '0 || dev_addr !== '0 || dev_wdata !== '0 ||
            acc_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: en=%b we=%b stall=%b err=%b rdata=%h required all 0",
                     {io_en, vga_en, dm_en}, dev_we, stall, addr_err, rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || dm_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: stall=%b dm_en=%b required 0 0", stall, dm_en);
        end
    endtask

    task automatic test_dm_read;
        dm_rdata = 32'hCAFEF00D;
        run_access(1, 0, 13'h0040, 3'b001, 2'b00, 0, '0, -1, 0, "dm_read");
        chk_int("dm_read stall_cycles", obs_stall, 2);
        chk_int("dm_read en_cycles", obs_en, 1);
        chk_int("dm_read en_seen", int'(obs_en_seen), 1);
        chk_int("dm_read dev_addr", int'(obs_addr), 32'h40);
        chk_int("dm_read dev_we", int'(obs_we), 0);
    endtask

    task automatic test_io_write;
        io_rdata = 32'h5555AAAA;
        run_access(0, 1, 13'h0004, 3'b100, 2'b10, 0, 32'h000000A5, -1, 0, "io_write");
        chk_int("io_write en_seen", int'(obs_en_seen), 4);
        chk_int("io_write en_cycles", obs_en, 1);
        chk_int("io_write dev_we", int'(obs_we), 1);
        chk_int("io_write dev_wdata", int'(obs_wdata), 32'hA5);
        chk_int("io_write dev_addr", int'(obs_addr), 4);
    endtask

    task automatic test_vga_read;
        vga_rdata = 32'h00000741;
        run_access(1, 0, 13'h1000, 3'b010, 2'b01, 0, '0, 4, 1, "vga_read");
        chk_int("vga_read stall_cycles", obs_stall, 5);
        chk_int("vga_read en_cycles", obs_en, 4);
        chk_int("vga_read en_seen", int'(obs_en_seen), 2);
    endtask

    task automatic test_vga_timeout;
        vga_rdata = 32'h12345678;
        run_access(1, 0, 13'h1004, 3'b010, 2'b01, 0, '0, -1, 0, "vga_timeout");
        chk_int("vga_timeout stall_cycles", obs_stall, 18);
        chk_int("vga_timeout en_cycles", obs_en, 17);
    endtask

    task automatic test_vga_ready_at_limit;
        vga_rdata = 32'h0BADBEEF;
        // ready pulses in the 16th WAIT cycle, together with the timeout
        run_access(1, 0, 13'h1008, 3'b010, 2'b01, 0, '0, 17, 0, "vga_ready_last");
        chk_int("vga_ready_last stall_cycles", obs_stall, 18);
    endtask

    task automatic test_invalid;
        dm_rdata = 32'h11112222;
        run_access(1, 0, 13'h0100, 3'b001, 2'b00, 1, '0, -1, 0, "iad_read");
        chk_int("iad_read stall_cycles", obs_stall, 1);
        chk_int("iad_read en_seen", int'(obs_en_seen), 0);
        run_access(1, 0, 13'h0100, 3'b000, 2'b00, 0, '0, -1, 0, "me_zero");
        chk_int("me_zero en_seen", int'(obs_en_seen), 0);
        run_access(0, 1, 13'h0100, 3'b011, 2'b00, 0, 32'hFFFF0000, -1, 0, "me_multi");
        chk_int("me_multi en_seen", int'({obs_en_seen, obs_we}), 0);
    endtask

    task automatic test_rw_priority;
        dm_rdata = 32'h0F0F0F0F;
        run_access(1, 0, 13'h0010, 3'b001, 2'b00, 0, '0, -1, 0, "pre_read");
        dm_rdata = 32'hDEADDEAD;
        run_access(1, 1, 13'h0014, 3'b001, 2'b00, 0, 32'h600DF00D, -1, 0, "rw_both");
        chk_int("rw_both dev_we", int'(obs_we), 1);
        chk_int("rw_both dev_wdata", int'(obs_wdata), 32'h600DF00D);
    endtask

    task automatic test_reset_mid_wait;
        mR = 1'b1; pAd = 13'h1010; mE = 3'b010; mB = 2'b01; iAd = 1'b0;
        vga_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (vga_en !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_active: vga_en=%b stall=%b required 1 1", vga_en, stall);
        end
        #1;
        rst_n = 1'b0;
        mR = 1'b0;
        #1;
        checks++;
        if (vga_en !== 1'b0 || stall !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL async_reset: vga_en=%b stall=%b rdata=%h required 0 0 0", vga_en, stall, rdata);
        end
        m_rdata = '0; m_acc = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        dm_rdata = 32'h87654321;
        run_access(1, 0, 13'h0044, 3'b001, 2'b00, 0, '0, -1, 0, "post_reset_dm");
        chk_int("post_reset_dm stall_cycles", obs_stall, 2);
        chk_int("post_reset_dm en_cycles", obs_en, 1);
    endtask

    task automatic test_back_to_back;
        logic [2:0] me;
        logic [1:0] mb;
        logic       wr;
        for (int i = 0; i < 8; i++) begin
            dm_rdata = $urandom;
            io_rdata = $urandom;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin me = 3'b001; mb = 2'b00; end
            else begin me = 3'b100; mb = 2'b10; end
            run_access(!wr, wr, AW'($urandom), me, mb, 0, $urandom, -1, (i % 2) == 1, "b2b");
            chk_int("b2b stall_cycles", obs_stall, 2);
            chk_int("b2b dev_we", int'(obs_we), int'(wr));
        end
    endtask

    initial begin
        test_reset();
        test_dm_read();
        test_io_write();
        test_vga_read();
        test_vga_timeout();
        test_vga_ready_at_limit();
        test_invalid();
        test_rw_priority();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequencing stage directly downstream of the memory address decoder in the MIPS32 SoC.
- Takes the CPU read/write request plus the decoded physical address, enable one-hot (mE), bus select (mB) and invalid-address flag (iAd).
- Drives exactly one target per access: data memory, VGA or I/O. Stalls the CPU until the access completes, registers the returned read data and flags decode or timeout errors.

Parameters:
- ADDR_W, 13, width of the physical address from the decoder.
- DATA_W, 32, data bus width.
- VGA_TIMEOUT, 16, maximum number of WAIT cycles allowed for vga_ready before an error is raised.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mR  in  1  CPU read request.
- mW  in  1  CPU write request.
- pAd  in  ADDR_W  physical address from the decoder.
- mE  in  3  target enable one-hot: bit0 data memory, bit1 VGA, bit2 I/O.
- mB  in  2  read-data select: 00 data memory, 01 VGA, 10 I/O.
- iAd  in  1  invalid-address flag from the decoder.
- wdata  in  DATA_W  CPU write data.
- dm_rdata, vga_rdata, io_rdata  in  DATA_W each  device read data (combinational while enabled).
- vga_ready  in  1  VGA access-complete strobe.
- dev_addr  out  ADDR_W  registered address to devices.
- dev_wdata  out  DATA_W  registered write data.
- dm_en, vga_en, io_en  out  1 each  device enables.
- dev_we  out  1  write strobe, qualified by the device enables.
- rdata  out  DATA_W  registered read data to the CPU.
- stall  out  1  CPU hold.
- addr_err  out  1  one-cycle error pulse.
- acc_cnt  out  16  access counter (optional feature).
- err_cnt  out  16  error counter (optional feature).

Behaviour:
- Reset is asynchronous, active-low. Reset state: IDLE. All outputs 0, timeout counter 0.
- States: IDLE, ACCESS, WAIT, DONE.
- stall = (state is ACCESS or WAIT) OR (state is IDLE and (mR|mW)).
  - stall is 0 in DONE and in IDLE with no request.
- IDLE, request present and iAd=0:
  - Latch pAd to dev_addr, wdata to dev_wdata, mE, mB and the write flag (mW).
  - Go to ACCESS.
- IDLE, request present and iAd=1:
  - Go to DONE with rdata<=0 and addr_err=1 during DONE.
  - No device enable is asserted.
- Simultaneous mR and mW: write wins.
- mE is not one-hot (including 000) while iAd=0: treat as invalid, same path as iAd=1.
- ACCESS (one cycle):
  - Assert the enable selected by the latched mE.
  - dev_we = latched write flag.
  - Data memory or I/O: capture the selected rdata at the clock edge (reads only; writes leave rdata unchanged), then go to DONE.
  - VGA with vga_ready=1: capture and go to DONE.
  - VGA with vga_ready=0: go to WAIT with the counter cleared.
- WAIT:
  - Hold vga_en and dev_we. Increment the counter each cycle.
  - vga_ready=1: capture and go to DONE.
  - Counter reaches VGA_TIMEOUT-1 with no ready: go to DONE with rdata<=0 and addr_err=1.
  - vga_ready and timeout in the same cycle: ready wins.
- DONE: enables 0, stall 0, always go to IDLE.
  - The CPU advances on this edge. A new request is seen in IDLE on the next cycle.
- Latency:
  - Data memory or I/O: 2 cycles request-to-DONE (stall high for 2 cycles).
  - VGA: 2+N cycles, where N is the number of WAIT cycles.
- Request dropped mid-access: ignored; the access completes.
- Reset asserted mid-access: immediate return to IDLE. Enables drop asynchronously.
- rdata holds its value until the next captured read or error.

Optional Feature:
- Macro: MEM_BUS_STATS_EN.
- Defined:
  - acc_cnt increments once per completed access (entry to DONE without error).
  - err_cnt increments once per addr_err pulse.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: acc_cnt and err_cnt are tied to 0 and no counter flops exist.

Test Plan:
- DM read: pAd=13'h0040, mE=001, mB=00, mR=1, dm_rdata=32'hCAFEF00D.
  - stall high for 2 cycles, dm_en high exactly 1 cycle, rdata=32'hCAFEF00D in DONE.
- I/O write: pAd=13'h0004, mE=100, mW=1, wdata=32'h000000A5.
  - io_en=1, dev_we=1 for 1 cycle, dev_wdata=32'hA5, dev_addr=4; rdata unchanged.
- VGA read with vga_ready after 3 WAIT cycles, vga_rdata=32'h00000741.
  - stall high 5 cycles, vga_en high 4 cycles, rdata=32'h741, addr_err=0.
- VGA with vga_ready stuck 0:
  - after 16 WAIT cycles, DONE with addr_err=1 and rdata=0; err_cnt=1 with MEM_BUS_STATS_EN.
- iAd=1 with mR=1:
  - no enable asserted, addr_err=1 for 1 cycle, stall 1 cycle, rdata=0.
- rst_n pulsed low during WAIT:
  - vga_en and stall go 0 immediately, state IDLE, next DM read completes normally in 2 cycles.
